// File: rtl/adc_sample_conditioner_pkg.sv
// adc_sample_conditioner shared types and constants.
// FSM encoding, mode codes, default scale factors.
package adc_cond_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_BCD,
    S_DONE
  } state_e;

  localparam logic MODE_CV  = 1'b0;
  localparam logic MODE_PCT = 1'b1;

  localparam int K_CV_DEF   = 205;
  localparam int K_PCT_DEF  = 100;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_BITS   = 4 * BCD_DIGITS;
  localparam int MAG_W      = 15;

  // |code| as 15 bits; the most negative code saturates
  function automatic logic [MAG_W-1:0] mag15(
    input logic [15:0] code
  );
    logic [15:0] neg;
    neg = ~code + 16'd1;
    if (!code[15])
      return code[MAG_W-1:0];
    else if (code == 16'h8000)
      return {MAG_W{1'b1}};
    else
      return neg[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/adc_sample_conditioner_if.sv
// adc_sample_conditioner sample/result bus.
// master = sample source + result sink, slave = conditioner.
interface adc_sample_conditioner_if;
  import adc_cond_pkg::*;

  logic [15:0]         data_in;
  logic                data_valid;
  logic                mode;
  logic [7:0]          numero;
  logic [BCD_BITS-1:0] bcd;
  logic                sign;
  logic                result_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output data_in, data_valid, mode,
    input  numero, bcd, sign,
    input  result_valid, busy, overrun
  );

  modport slave (
    input  data_in, data_valid, mode,
    output numero, bcd, sign,
    output result_valid, busy, overrun
  );

endinterface

// File: rtl/adc_sample_conditioner_bin2bcd.sv
// bin2bcd_seq: 8-bit binary to 3-digit BCD, one bit per cycle.
// done_o marks the final iteration; bcd_o is then the finished code.
module bin2bcd_seq
  import adc_cond_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [7:0]          bin_i,
  output logic                done_o,
  output logic [BCD_BITS-1:0] bcd_o
);

  logic [7:0]          bin_q;
  logic [BCD_BITS-1:0] acc_q, acc_d, adj;
  logic [3:0]          cnt_q;

  // add-3 correction on every digit >= 5, then shift in the next bit
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_d  = {adj[BCD_BITS-2:0], bin_q[7]};
    bcd_o  = acc_d;
    done_o = (cnt_q == 4'd1);
  end

  // load on start, then iterate eight times MSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      bin_q <= bin_i;
      acc_q <= '0;
      cnt_q <= 4'd8;
    end else if (cnt_q != 4'd0) begin
      bin_q <= {bin_q[6:0], 1'b0};
      acc_q <= acc_d;
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: moving average, scale to 8 bits, BCD.
// Build option ADC_NEG_CLAMP_EN: clamp negative codes to 0, sign held 0.
module adc_sample_conditioner
  import adc_cond_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int K_CV     = K_CV_DEF,
  parameter int K_PCT    = K_PCT_DEF
) (
  input logic                     clk,
  input logic                     rst,
  adc_sample_conditioner_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW    = MAG_W + AVG_LOG2;

  state_e              state_q;
  logic [15:0]         data_q;
  logic                mode_q, prev_mode_q;
  logic [MAG_W-1:0]    buf_q [DEPTH];
  logic [SW-1:0]       sum_q, sum_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [MAG_W-1:0]    mag, avg;
  logic                flush;
  logic [31:0]         prod, scaled;
  logic [7:0]          num_d, num_pend_q, numero_q;
  logic [BCD_BITS-1:0] bcd_q, dd_bcd;
  logic                dd_done, dd_start;
  logic                sign_q, rv_q, busy_q, ovr_q;

  // window input, running sum and scaled result
  always_comb begin
`ifdef ADC_NEG_CLAMP_EN
    mag = data_q[15] ? '0 : data_q[MAG_W-1:0];
`else
    mag = mag15(data_q);
`endif
    flush = (mode_q != prev_mode_q);
    if (flush)
      sum_d = SW'(mag);
    else
      sum_d = sum_q + SW'(mag) - SW'(buf_q[ptr_q]);
    if (ptr_q == PW'(DEPTH - 1))
      ptr_d = '0;
    else
      ptr_d = ptr_q + PW'(1);
    avg = MAG_W'(sum_q >> AVG_LOG2);
    if (mode_q == MODE_PCT)
      prod = 32'(avg) * 32'(K_PCT);
    else
      prod = 32'(avg) * 32'(K_CV);
    scaled   = prod >> 15;
    num_d    = (|scaled[31:8]) ? 8'hFF : scaled[7:0];
    dd_start = (state_q == S_SCALE);
  end

  // sliding window: mode change empties it before the new sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        buf_q[i] <= '0;
      sum_q       <= '0;
      ptr_q       <= '0;
      prev_mode_q <= 1'b0;
    end else if (state_q == S_ACCUM) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          buf_q[i] <= '0;
      end
      buf_q[ptr_q] <= mag;
      sum_q        <= sum_d;
      ptr_q        <= ptr_d;
      prev_mode_q  <= mode_q;
    end
  end

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (dd_start),
    .bin_i   (num_d),
    .done_o  (dd_done),
    .bcd_o   (dd_bcd)
  );

  // sequencing FSM with registered result and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mode_q     <= 1'b0;
      num_pend_q <= '0;
      numero_q   <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      rv_q       <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (bus.data_valid && state_q != S_IDLE)
        ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (bus.data_valid) begin
            data_q  <= bus.data_in;
            mode_q  <= bus.mode;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: state_q <= S_SCALE;
        S_SCALE: begin
          num_pend_q <= num_d;
          state_q    <= S_BCD;
        end
        S_BCD: begin
          if (dd_done) begin
            numero_q <= num_pend_q;
            bcd_q    <= dd_bcd;
`ifdef ADC_NEG_CLAMP_EN
            sign_q   <= 1'b0;
`else
            sign_q   <= data_q[15];
`endif
            rv_q     <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.numero       = numero_q;
  assign bus.bcd          = bcd_q;
  assign bus.sign         = sign_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: vector table plus
// hand-written overrun, reset-abort and single-tap sequences.
module tb_adc_sample_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  adc_sample_conditioner_if bus ();
  adc_sample_conditioner_if bus0 ();

  adc_sample_conditioner u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adc_sample_conditioner #(.AVG_LOG2(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic [15:0] d;
    logic        m;
    logic [7:0]  num;
    logic [11:0] bcd;
    logic        sgn;
  } vec_t;

  vec_t vt [10];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic m);
    @(negedge clk);
    bus.data_in    = d;
    bus.mode       = m;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_rv(input int start, output int lat);
    lat = start;
    while (!bus.result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_rv(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    vt[0] = '{16'h7FFF, 1'b1, 8'd24,  12'h024, 1'b0};
    vt[1] = '{16'h7FFF, 1'b1, 8'd49,  12'h049, 1'b0};
    vt[2] = '{16'h7FFF, 1'b1, 8'd74,  12'h074, 1'b0};
    vt[3] = '{16'h7FFF, 1'b1, 8'd99,  12'h099, 1'b0};
    vt[4] = '{16'h7FFF, 1'b0, 8'd51,  12'h051, 1'b0};
    vt[5] = '{16'h7FFF, 1'b0, 8'd102, 12'h102, 1'b0};
    vt[6] = '{16'h7FFF, 1'b0, 8'd153, 12'h153, 1'b0};
    vt[7] = '{16'h7FFF, 1'b0, 8'd204, 12'h204, 1'b0};
`ifdef ADC_NEG_CLAMP_EN
    vt[8] = '{16'hC000, 1'b1, 8'd0,   12'h000, 1'b0};
    vt[9] = '{16'h0001, 1'b1, 8'd0,   12'h000, 1'b0};
`else
    vt[8] = '{16'hC000, 1'b1, 8'd12,  12'h012, 1'b1};
    vt[9] = '{16'h0001, 1'b1, 8'd12,  12'h012, 1'b0};
`endif

    bus.data_in     = '0;
    bus.mode        = 1'b0;
    bus.data_valid  = 1'b0;
    bus0.data_in    = '0;
    bus0.mode       = 1'b0;
    bus0.data_valid = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_numero", 32'(bus.numero), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_flags",
        32'({bus.sign, bus.result_valid,
             bus.busy, bus.overrun}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      send(vt[i].d, vt[i].m);
      chk($sformatf("busy_t1[%0d]", i),
          32'(bus.busy), 32'd1);
      wait_rv(1, lat);
      chk($sformatf("lat[%0d]", i), 32'(lat), 32'd11);
      chk($sformatf("numero[%0d]", i),
          32'(bus.numero), 32'(vt[i].num));
      chk($sformatf("bcd[%0d]", i),
          32'(bus.bcd), 32'(vt[i].bcd));
      chk($sformatf("sign[%0d]", i),
          32'(bus.sign), 32'(vt[i].sgn));
      chk($sformatf("busy_rv[%0d]", i),
          32'(bus.busy), 32'd1);
      @(negedge clk);
      chk($sformatf("rv_pulse[%0d]", i),
          32'(bus.result_valid), 32'd0);
      chk($sformatf("busy_end[%0d]", i),
          32'(bus.busy), 32'd0);
    end
    chk("ovr_clean", 32'(bus.overrun), 32'd0);

    // single-tap instance, most negative code
    @(negedge clk);
    bus0.data_in    = 16'h8000;
    bus0.mode       = 1'b1;
    bus0.data_valid = 1'b1;
    @(negedge clk);
    bus0.data_valid = 1'b0;
    lat = 1;
    while (!bus0.result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_lat", 32'(lat), 32'd11);
`ifdef ADC_NEG_CLAMP_EN
    chk("t4_numero", 32'(bus0.numero), 32'd0);
    chk("t4_sign", 32'(bus0.sign), 32'd0);
`else
    chk("t4_numero", 32'(bus0.numero), 32'd99);
    chk("t4_sign", 32'(bus0.sign), 32'd1);
`endif

    // reset in the middle of a conversion
    send(16'h7FFF, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_numero", 32'(bus.numero), 32'd0);
    chk("t5_bcd", 32'(bus.bcd), 32'd0);
    chk("t5_flags",
        32'({bus.sign, bus.result_valid,
             bus.busy, bus.overrun}), 32'd0);
    rst = 1'b0;
    count_rv(15, seen);
    chk("t5_abort", 32'(seen), 32'd0);
    send(16'h7FFF, 1'b1);
    wait_rv(1, lat);
    chk("t5_lat", 32'(lat), 32'd11);
    chk("t5_fresh", 32'(bus.numero), 32'd24);

    // strobe landing on the DONE cycle
    send(16'h7FFF, 1'b1);
    wait_rv(1, lat);
    chk("t6_lat", 32'(lat), 32'd11);
    bus.data_in    = 16'h0000;
    bus.mode       = 1'b0;
    bus.data_valid = 1'b1;
    chk("t6_numero", 32'(bus.numero), 32'd49);
    chk("t6_bcd", 32'(bus.bcd), 32'h049);
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk("t6_ovr", 32'(bus.overrun), 32'd1);
    count_rv(20, seen);
    chk("t6_extra", 32'(seen), 32'd0);

    // strobe five cycles after an accepted one
    pulse_rst();
    chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);
    send(16'h7FFF, 1'b1);
    repeat (4) @(negedge clk);
    bus.data_in    = 16'h0100;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    wait_rv(6, lat);
    chk("t3_lat", 32'(lat), 32'd11);
    chk("t3_numero", 32'(bus.numero), 32'd24);
    chk("t3_ovr", 32'(bus.overrun), 32'd1);
    count_rv(20, seen);
    chk("t3_extra", 32'(seen), 32'd0);
    send(16'h7FFF, 1'b1);
    wait_rv(1, lat);
    chk("t3_next", 32'(bus.numero), 32'd49);
    chk("t3_sticky", 32'(bus.overrun), 32'd1);
    pulse_rst();
    chk("t3_rst_ovr", 32'(bus.overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
